// File: rtl/baej_pkg.sv
// Shared constants for the Baej 16-bit processor control path.
// Opcodes, ALU functions, write-back selects and FSM state codes.
package baej_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_SLT  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_BNE  = 4'h9;
  localparam logic [3:0] OP_J    = 4'hA;
  localparam logic [3:0] OP_CALL = 4'hB;
  localparam logic [3:0] OP_RET  = 4'hC;
  localparam logic [3:0] OP_IN   = 4'hD;
  localparam logic [3:0] OP_OUT  = 4'hE;
  localparam logic [3:0] OP_NOP  = 4'hF;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_SLT   = 3'b100;
  localparam logic [2:0] ALU_PASSB = 3'b111;

  localparam logic [1:0] RS_ALU = 2'd0;
  localparam logic [1:0] RS_MEM = 2'd1;
  localparam logic [1:0] RS_IO  = 2'd2;
  localparam logic [1:0] RS_RA  = 2'd3;

  typedef enum logic [4:0] {
    S_FETCH    = 5'd0,
    S_DECODE   = 5'd1,
    S_ALU_R    = 5'd2,
    S_ALU_WB   = 5'd3,
    S_ADDI_EX  = 5'd4,
    S_ADDI_WB  = 5'd5,
    S_MEM_ADDR = 5'd6,
    S_LW_RD    = 5'd7,
    S_LW_WB    = 5'd8,
    S_SW_WR    = 5'd9,
    S_BRANCH   = 5'd10,
    S_JUMP     = 5'd11,
    S_CALL     = 5'd12,
    S_RET      = 5'd13,
    S_IN_WB    = 5'd14,
    S_OUT      = 5'd15,
    S_RESET    = 5'd31
  } state_e;

endpackage

// File: rtl/baej_control_fsm.sv
// Multi-cycle control FSM for the Baej processor.
// Sequences PC/memory and register/ALU strobes from the opcode.
module baej_control_fsm
  import baej_pkg::*;
(
  input  logic       clk,
  input  logic       Reset,
  input  logic [3:0] op,
  output logic       PCsrc,
  output logic       writePC,
  output logic       writeRA,
  output logic       ImRPC,
  output logic       Memsrc,
  output logic       MemW1,
  output logic       MemW2,
  output logic       MemR1,
  output logic       MemR2,
  output logic       writeCR,
  output logic       writeImR,
  output logic       backup,
  output logic       restore,
  output logic [1:0] Regsrc,
  output logic       RegW1,
  output logic       RegW2,
  output logic       RegR1,
  output logic       RegR2,
  output logic       ALUsrc,
  output logic       cmpeq,
  output logic       cmpne,
  output logic [2:0] ALUop,
  output logic [4:0] current_state,
  output logic [4:0] next_state
);

  state_e     state_q, state_d;
  logic [2:0] alu_r_op;

  // State register; reset wins even mid-instruction
  always_ff @(posedge clk) begin
    if (Reset) state_q <= S_RESET;
    else       state_q <= state_d;
  end

  // Next-state decode; op only matters in DECODE and MEM_ADDR
  always_comb begin
    state_d = S_FETCH;
    if (Reset) begin
      state_d = S_RESET;
    end else begin
      case (state_q)
        S_FETCH:   state_d = S_DECODE;
        S_DECODE: begin
          case (op)
            OP_ADD, OP_SUB, OP_AND,
            OP_OR, OP_SLT:   state_d = S_ALU_R;
            OP_ADDI:         state_d = S_ADDI_EX;
            OP_LW, OP_SW:    state_d = S_MEM_ADDR;
            OP_BEQ, OP_BNE:  state_d = S_BRANCH;
            OP_J:            state_d = S_JUMP;
            OP_CALL:         state_d = S_CALL;
            OP_RET:          state_d = S_RET;
            OP_IN:           state_d = S_IN_WB;
            OP_OUT:          state_d = S_OUT;
            default:         state_d = S_FETCH;
          endcase
        end
        S_MEM_ADDR: begin
          if (op == OP_SW)      state_d = S_SW_WR;
          else if (op == OP_LW) state_d = S_LW_RD;
          else                  state_d = S_FETCH;
        end
        S_ALU_R:   state_d = S_ALU_WB;
        S_ADDI_EX: state_d = S_ADDI_WB;
        S_LW_RD:   state_d = S_LW_WB;
        default:   state_d = S_FETCH;
      endcase
    end
  end

  // R-type ALU function comes straight from the low opcode bits
  assign alu_r_op = (op <= OP_SLT) ? op[2:0] : ALU_ADD;

  // Output decode: Moore on state, except ALUop/compare select
  always_comb begin
    PCsrc    = 1'b0;
    writePC  = 1'b0;
    writeRA  = 1'b0;
    ImRPC    = 1'b0;
    Memsrc   = 1'b0;
    MemW1    = 1'b0;
    MemW2    = 1'b0;
    MemR1    = 1'b0;
    MemR2    = 1'b0;
    writeCR  = 1'b0;
    writeImR = 1'b0;
    backup   = 1'b0;
    restore  = 1'b0;
    Regsrc   = RS_ALU;
    RegW1    = 1'b0;
    RegW2    = 1'b0;
    RegR1    = 1'b0;
    RegR2    = 1'b0;
    ALUsrc   = 1'b0;
    cmpeq    = 1'b0;
    cmpne    = 1'b0;
    ALUop    = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        MemR1   = 1'b1;
        writePC = 1'b1;
      end
      S_DECODE: begin
        RegR1    = 1'b1;
        RegR2    = 1'b1;
        writeImR = 1'b1;
      end
      S_ALU_R: ALUop = alu_r_op;
      S_ALU_WB: begin
        RegW1 = 1'b1;
        ALUop = alu_r_op;
      end
      S_ADDI_EX:  ALUsrc = 1'b1;
      S_ADDI_WB: begin
        ALUsrc = 1'b1;
        RegW1  = 1'b1;
      end
      S_MEM_ADDR: ALUsrc = 1'b1;
      S_LW_RD: begin
        MemR2  = 1'b1;
        Memsrc = 1'b1;
        ALUsrc = 1'b1;
      end
      S_LW_WB: begin
        RegW1  = 1'b1;
        Regsrc = RS_MEM;
      end
      S_SW_WR: begin
        MemW2  = 1'b1;
        Memsrc = 1'b1;
        ALUsrc = 1'b1;
        RegR2  = 1'b1;
      end
      // writePC is qualified by the compare result in the datapath
      S_BRANCH: begin
        ALUop   = ALU_SUB;
        cmpeq   = (op == OP_BEQ);
        cmpne   = (op == OP_BNE);
        writePC = 1'b1;
        PCsrc   = 1'b1;
        ImRPC   = 1'b1;
      end
      S_JUMP: begin
        writePC = 1'b1;
        PCsrc   = 1'b1;
      end
      S_CALL: begin
        writeRA = 1'b1;
        backup  = 1'b1;
        writePC = 1'b1;
        PCsrc   = 1'b1;
      end
      S_RET: begin
        restore = 1'b1;
        writePC = 1'b1;
        PCsrc   = 1'b1;
        ImRPC   = 1'b1;
      end
      S_IN_WB: begin
        RegW1  = 1'b1;
        Regsrc = RS_IO;
      end
      S_OUT: begin
        RegR1   = 1'b1;
        writeCR = 1'b1;
      end
      default: ;
    endcase
  end

  assign current_state = state_q;
  assign next_state    = state_d;

endmodule

// File: tb/tb_baej_control_fsm.sv
// Self-checking bench for baej_control_fsm.
// Table vectors, random instruction stream, reset corners.
module tb_baej_control_fsm;

  logic       clk;
  logic       Reset;
  logic [3:0] op;
  logic       PCsrc, writePC, writeRA, ImRPC;
  logic       Memsrc, MemW1, MemW2, MemR1, MemR2;
  logic       writeCR, writeImR, backup, restore;
  logic [1:0] Regsrc;
  logic       RegW1, RegW2, RegR1, RegR2, ALUsrc, cmpeq, cmpne;
  logic [2:0] ALUop;
  logic [4:0] current_state, next_state;

  typedef struct packed {
    logic       PCsrc;
    logic       writePC;
    logic       writeRA;
    logic       ImRPC;
    logic       Memsrc;
    logic       MemW1;
    logic       MemW2;
    logic       MemR1;
    logic       MemR2;
    logic       writeCR;
    logic       writeImR;
    logic       backup;
    logic       restore;
    logic [1:0] Regsrc;
    logic       RegW1;
    logic       RegW2;
    logic       RegR1;
    logic       RegR2;
    logic       ALUsrc;
    logic       cmpeq;
    logic       cmpne;
    logic [2:0] ALUop;
  } outs_t;

  typedef struct {
    logic [3:0]      op;
    int              len;
    logic [5:0][4:0] seq;
  } vec_t;

  outs_t act;
  int    checks = 0;
  int    errors = 0;

  assign act = {PCsrc, writePC, writeRA, ImRPC, Memsrc, MemW1,
                MemW2, MemR1, MemR2, writeCR, writeImR, backup,
                restore, Regsrc, RegW1, RegW2, RegR1, RegR2,
                ALUsrc, cmpeq, cmpne, ALUop};

  baej_control_fsm dut (
    .clk(clk), .Reset(Reset), .op(op),
    .PCsrc(PCsrc), .writePC(writePC), .writeRA(writeRA),
    .ImRPC(ImRPC), .Memsrc(Memsrc), .MemW1(MemW1),
    .MemW2(MemW2), .MemR1(MemR1), .MemR2(MemR2),
    .writeCR(writeCR), .writeImR(writeImR), .backup(backup),
    .restore(restore), .Regsrc(Regsrc), .RegW1(RegW1),
    .RegW2(RegW2), .RegR1(RegR1), .RegR2(RegR2),
    .ALUsrc(ALUsrc), .cmpeq(cmpeq), .cmpne(cmpne),
    .ALUop(ALUop), .current_state(current_state),
    .next_state(next_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Strobes each state must drive, straight from the state table
  function automatic outs_t exp_out(input logic [4:0] s,
                                    input logic [3:0] o);
    outs_t e;
    e = '0;
    case (s)
      5'd0:  begin e.MemR1 = 1; e.writePC = 1; end
      5'd1:  begin e.RegR1 = 1; e.RegR2 = 1; e.writeImR = 1; end
      5'd2:  e.ALUop = (o <= 4'd4) ? o[2:0] : 3'd0;
      5'd3:  begin
        e.RegW1 = 1;
        e.ALUop = (o <= 4'd4) ? o[2:0] : 3'd0;
      end
      5'd4:  e.ALUsrc = 1;
      5'd5:  begin e.ALUsrc = 1; e.RegW1 = 1; end
      5'd6:  e.ALUsrc = 1;
      5'd7:  begin e.MemR2 = 1; e.Memsrc = 1; e.ALUsrc = 1; end
      5'd8:  begin e.RegW1 = 1; e.Regsrc = 2'd1; end
      5'd9:  begin
        e.MemW2 = 1; e.Memsrc = 1; e.ALUsrc = 1; e.RegR2 = 1;
      end
      5'd10: begin
        e.ALUop = 3'b001;
        e.cmpeq = (o == 4'h8);
        e.cmpne = (o == 4'h9);
        e.writePC = 1; e.PCsrc = 1; e.ImRPC = 1;
      end
      5'd11: begin e.writePC = 1; e.PCsrc = 1; end
      5'd12: begin
        e.writeRA = 1; e.backup = 1; e.writePC = 1; e.PCsrc = 1;
      end
      5'd13: begin
        e.restore = 1; e.writePC = 1; e.PCsrc = 1; e.ImRPC = 1;
      end
      5'd14: begin e.RegW1 = 1; e.Regsrc = 2'd2; end
      5'd15: begin e.RegR1 = 1; e.writeCR = 1; end
      default: ;
    endcase
    return e;
  endfunction

  // Instruction-level model: path of states by instruction class
  task automatic model_path(input logic [3:0] o, output int n,
                            output logic [5:0][4:0] s);
    s = '0;
    s[0] = 5'd0;
    s[1] = 5'd1;
    n = 2;
    if (o <= 4'd4) begin
      s[2] = 5'd2; s[3] = 5'd3; n = 4;
    end else if (o == 4'h5) begin
      s[2] = 5'd4; s[3] = 5'd5; n = 4;
    end else if (o == 4'h6) begin
      s[2] = 5'd6; s[3] = 5'd7; s[4] = 5'd8; n = 5;
    end else if (o == 4'h7) begin
      s[2] = 5'd6; s[3] = 5'd9; n = 4;
    end else if (o == 4'h8 || o == 4'h9) begin
      s[2] = 5'd10; n = 3;
    end else if (o != 4'hF) begin
      s[2] = 5'(o) + 5'd1; n = 3;
    end
  endtask

  function automatic vec_t mkv(input logic [3:0] o, input int n,
                               input logic [4:0] a2,
                               input logic [4:0] a3,
                               input logic [4:0] a4);
    vec_t v;
    v.op  = o;
    v.len = n;
    v.seq = {5'd0, a4, a3, a2, 5'd1, 5'd0};
    return v;
  endfunction

  // Walk one instruction starting in FETCH; op is junk in FETCH
  task automatic run_seq(input string tag, input logic [3:0] o,
                         input int n, input logic [5:0][4:0] s);
    logic [4:0] nx;
    for (int i = 0; i < n; i++) begin
      op = (i == 0) ? 4'($urandom) : o;
      #1;
      nx = (i + 1 < n) ? s[i+1] : 5'd0;
      chk({tag, " state"}, 32'(current_state), 32'(s[i]));
      chk({tag, " next"}, 32'(next_state), 32'(nx));
      chk({tag, " outs"}, 32'(act), 32'(exp_out(s[i], o)));
      step();
    end
  endtask

  vec_t            vecs[10];
  int              n;
  logic [5:0][4:0] p;
  logic [3:0]      ro;

  initial begin
    vecs[0] = mkv(4'h0, 4, 5'd2, 5'd3, 5'd0);
    vecs[1] = mkv(4'h4, 4, 5'd2, 5'd3, 5'd0);
    vecs[2] = mkv(4'h6, 5, 5'd6, 5'd7, 5'd8);
    vecs[3] = mkv(4'h7, 4, 5'd6, 5'd9, 5'd0);
    vecs[4] = mkv(4'h8, 3, 5'd10, 5'd0, 5'd0);
    vecs[5] = mkv(4'h9, 3, 5'd10, 5'd0, 5'd0);
    vecs[6] = mkv(4'hB, 3, 5'd12, 5'd0, 5'd0);
    vecs[7] = mkv(4'hC, 3, 5'd13, 5'd0, 5'd0);
    vecs[8] = mkv(4'h5, 4, 5'd4, 5'd5, 5'd0);
    vecs[9] = mkv(4'hF, 2, 5'd0, 5'd0, 5'd0);

    Reset = 1'b1;
    op    = 4'hF;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("reset state", 32'(current_state), 32'd31);
      chk("reset next", 32'(next_state), 32'd31);
      chk("reset outs", 32'(act), 32'd0);
    end
    Reset = 1'b0;
    #1;
    chk("release next", 32'(next_state), 32'd0);
    step();
    chk("fetch state", 32'(current_state), 32'd0);
    chk("fetch MemR1", 32'(MemR1), 32'd1);
    chk("fetch writePC", 32'(writePC), 32'd1);

    foreach (vecs[k])
      run_seq($sformatf("vec op%h", vecs[k].op), vecs[k].op,
              vecs[k].len, vecs[k].seq);

    op = 4'h0;
    step(); step(); step();
    chk("add wb RegW1", 32'(RegW1), 32'd1);
    chk("add wb ALUop", 32'(ALUop), 32'd0);
    step();
    op = 4'h4;
    step(); step(); step();
    chk("slt wb ALUop", 32'(ALUop), 32'd4);
    step();
    op = 4'h8;
    step(); step();
    chk("beq cmpeq", 32'(cmpeq), 32'd1);
    chk("beq cmpne", 32'(cmpne), 32'd0);
    step();
    chk("beq back fetch", 32'(current_state), 32'd0);

    op = 4'h6;
    step(); step(); step();
    chk("lw rd state", 32'(current_state), 32'd7);
    Reset = 1'b1;
    #1;
    chk("mid reset next", 32'(next_state), 32'd31);
    step();
    chk("mid reset state", 32'(current_state), 32'd31);
    chk("mid reset outs", 32'(act), 32'd0);
    Reset = 1'b0;
    step();
    chk("post reset fetch", 32'(current_state), 32'd0);

    for (int k = 0; k < 150; k++) begin
      ro = 4'($urandom_range(0, 15));
      model_path(ro, n, p);
      run_seq($sformatf("rnd op%h", ro), ro, n, p);
    end
    chk("final fetch", 32'(current_state), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
